// File: rtl/evt_toggle_tx_pkg.sv
// Shared definitions for the toggle-handshake event transmitter.
// Holds the FSM encoding and the synchronizer depth floor.
package evt_toggle_tx_pkg;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_WAIT_ACK = 1'b1
    } state_t;

    localparam int SYNC_STAGES_MIN = 2;

    // Fewer than two flops gives no metastability settling time, so the depth is floored.
    function automatic int clamp_stages(input int n);
        return (n < SYNC_STAGES_MIN) ? SYNC_STAGES_MIN : n;
    endfunction

endpackage

// File: rtl/evt_toggle_tx_sync_bit.sv
// Single-bit multi-flop synchronizer for a level arriving from another clock domain.
// All flops clear on the asynchronous active-low reset.
module sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] sync_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[STAGES-2:0], d};
        end
    end

    assign q = sync_reg[STAGES-1];

endmodule

// File: rtl/evt_toggle_tx.sv
// Transmit side of the toggle-handshake event crossing: queues event pulses and
// launches them one at a time as req_tgl transitions, each held until ack_tgl answers.
module evt_toggle_tx
    import evt_toggle_tx_pkg::*;
#(
    parameter int CNT_W       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             set,
    input  logic             ack_tgl,
    input  logic             clr_ovf,
    output logic             req_tgl,
    output logic             busy,
    output logic [CNT_W-1:0] pending,
    output logic             overflow
);

    localparam int               STAGES   = clamp_stages(SYNC_STAGES);
    localparam logic [CNT_W-1:0] PEND_MAX = '1;

    logic             ack_s;
    logic             ack_d_reg;
    logic             ack_evt;
    state_t           state_reg;
    logic             req_reg;
    logic             ovf_reg;
    logic [CNT_W-1:0] pend_reg;
    logic [CNT_W-1:0] pend_next;
    logic             pend_nz;
    logic             launch;
    logic             take_q;
    logic             inc;
    logic             drop;

    sync_bit #(
        .STAGES(STAGES)
    ) u_ack_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (ack_tgl),
        .q     (ack_s)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_d_reg <= 1'b0;
        end else begin
            ack_d_reg <= ack_s;
        end
    end

    assign ack_evt = ack_s ^ ack_d_reg;

    // A launch prefers a queued event; only with an empty queue is this cycle's set sent directly.
    assign pend_nz = |pend_reg;
    assign launch  = (state_reg == ST_IDLE) && (pend_nz || set);
    assign take_q  = launch && pend_nz;
    assign inc     = set && !(launch && !pend_nz);
    assign drop    = inc && !take_q && (pend_reg == PEND_MAX);

    always_comb begin
        pend_next = pend_reg;
        if (inc && !take_q && !drop) begin
            pend_next = pend_reg + 1'b1;
        end else if (take_q && !inc) begin
            pend_next = pend_reg - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            req_reg   <= 1'b0;
            pend_reg  <= '0;
            ovf_reg   <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    // An ack_evt seen here is stale and deliberately ignored.
                    if (launch) begin
                        req_reg   <= ~req_reg;
                        state_reg <= ST_WAIT_ACK;
                    end
                end
                ST_WAIT_ACK: begin
                    if (ack_evt) begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
            pend_reg <= pend_next;
            ovf_reg  <= drop | (ovf_reg & ~clr_ovf);
        end
    end

    assign req_tgl  = req_reg;
    assign busy     = (state_reg == ST_WAIT_ACK);
    assign pending  = pend_reg;
    assign overflow = ovf_reg;

endmodule

// File: tb/tb_evt_toggle_tx.sv
// Randomized and directed bench for evt_toggle_tx against an event-count model
// that tracks queue depth, outstanding request and ack arrival edges.
module tb_evt_toggle_tx;

    localparam int CNT_W = 4;
    localparam int SS    = 2;
    localparam int PMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             set = 1'b0;
    logic             ack_tgl = 1'b0;
    logic             clr_ovf = 1'b0;
    logic             req_tgl;
    logic             busy;
    logic [CNT_W-1:0] pending;
    logic             overflow;

    evt_toggle_tx #(
        .CNT_W       (CNT_W),
        .SYNC_STAGES (SS)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .set      (set),
        .ack_tgl  (ack_tgl),
        .clr_ovf  (clr_ovf),
        .req_tgl  (req_tgl),
        .busy     (busy),
        .pending  (pending),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    int edge_n = 0;
    always @(posedge clk) edge_n <= edge_n + 1;

    int errors = 0;
    int checks = 0;

    // Model state: queued count, outstanding flag, request phase, sticky drop flag.
    int m_pend = 0;
    bit m_busy = 0;
    bit m_req  = 0;
    bit m_ovf  = 0;
    int ack_evt_edges[$];
    int ack_due[$];
    bit auto_ack  = 1;
    int ack_delay = 5;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, edge_n);
        end
    endtask

    task automatic model_reset();
        m_pend = 0;
        m_busy = 0;
        m_req  = 0;
        m_ovf  = 0;
        ack_evt_edges.delete();
        ack_due.delete();
    endtask

    // One clock cycle: drive inputs, advance the model, compare all outputs.
    task automatic step(input bit s, input bit c, input bit extra_tog);
        int e;
        bit tog;
        bit aevt;
        bit drop;
        e    = edge_n + 1;
        tog  = extra_tog;
        aevt = 1'b0;
        drop = 1'b0;
        foreach (ack_due[i]) if (ack_due[i] == e) tog = ~tog;
        ack_due = ack_due.find(x) with (x != e);
        set     = s;
        clr_ovf = c;
        if (tog) begin
            ack_tgl = ~ack_tgl;
            ack_evt_edges.push_back(e + SS);
        end
        foreach (ack_evt_edges[i]) if (ack_evt_edges[i] == e) aevt = 1'b1;
        ack_evt_edges = ack_evt_edges.find(x) with (x > e);

        if (!m_busy) begin
            if (m_pend > 0 || s) begin
                if (m_pend > 0) begin
                    m_pend--;
                    if (s) m_pend++;
                end
                m_req  = ~m_req;
                m_busy = 1'b1;
                if (auto_ack) ack_due.push_back(e + ack_delay);
            end
        end else begin
            if (aevt) m_busy = 1'b0;
            if (s) begin
                if (m_pend == PMAX) drop = 1'b1;
                else m_pend++;
            end
        end
        if (drop) m_ovf = 1'b1;
        else if (c) m_ovf = 1'b0;

        @(posedge clk);
        @(negedge clk);
        check_val("req_tgl", req_tgl, m_req);
        check_val("busy", busy, m_busy);
        check_val("pending", pending, m_pend);
        check_val("overflow", overflow, m_ovf);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_val("rst_req", req_tgl, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_pend", pending, 0);
        check_val("rst_ovf", overflow, 0);
        model_reset();
        rst_n = 1'b1;

        // Single event with ack returned 5 cycles after the request.
        auto_ack = 1; ack_delay = 5;
        step(1, 0, 0);
        check_val("single_req", req_tgl, 1);
        check_val("single_busy", busy, 1);
        repeat (12) step(0, 0, 0);
        check_val("single_done", busy, 0);

        // Burst of three.
        step(1, 0, 0);
        step(1, 0, 0);
        step(1, 0, 0);
        check_val("burst_pend", pending, 2);
        repeat (40) step(0, 0, 0);
        check_val("burst_req", req_tgl, 0);
        check_val("burst_pend0", pending, 0);

        // Overflow with ack held off.
        auto_ack = 0;
        repeat (17) step(1, 0, 0);
        check_val("ovf_pend", pending, 15);
        check_val("ovf_flag", overflow, 1);
        step(0, 1, 0);
        check_val("ovf_clr", overflow, 0);
        step(1, 1, 0);
        check_val("ovf_clr_vs_set", overflow, 1);
        step(0, 1, 0);
        auto_ack = 1;
        step(0, 0, 1);
        repeat (200) step(0, 0, 0);
        check_val("drain_pend", pending, 0);
        check_val("drain_busy", busy, 0);

        // Spurious ack in IDLE.
        step(0, 0, 1);
        repeat (4) step(0, 0, 0);
        check_val("spur_busy", busy, 0);
        step(1, 0, 0);
        check_val("spur_launch", busy, 1);
        repeat (12) step(0, 0, 0);

        // Set arriving in the ack_evt cycle with one queued event.
        auto_ack = 0;
        step(1, 0, 0);
        step(1, 0, 0);
        step(0, 0, 1);
        step(0, 0, 0);
        step(1, 0, 0);
        check_val("simul_pend", pending, 2);
        check_val("simul_idle", busy, 0);
        step(0, 0, 0);
        check_val("simul_pend1", pending, 1);
        check_val("simul_launch", busy, 1);
        auto_ack = 1;
        step(0, 0, 1);
        repeat (40) step(0, 0, 0);

        // Asynchronous reset mid-transfer.
        auto_ack = 0;
        repeat (5) step(1, 0, 0);
        check_val("prerst_pend", pending, 4);
        #2 rst_n = 1'b0;
        #1;
        check_val("arst_req", req_tgl, 0);
        check_val("arst_busy", busy, 0);
        check_val("arst_pend", pending, 0);
        check_val("arst_ovf", overflow, 0);
        @(negedge clk);
        @(negedge clk);
        set = 0; clr_ovf = 0; ack_tgl = 0;
        model_reset();
        rst_n = 1'b1;
        step(1, 0, 0);
        check_val("postrst_req", req_tgl, 1);
        step(0, 0, 1);
        auto_ack = 1;
        repeat (10) step(0, 0, 0);

        // Randomized traffic, with periods of withheld ack to reach saturation.
        for (int i = 0; i < 3000; i++) begin
            bit s;
            bit c;
            bit sp;
            auto_ack  = ((i % 600) >= 200);
            ack_delay = int'($urandom_range(1, 8));
            s  = auto_ack ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 0);
            c  = ($urandom_range(0, 15) == 0);
            sp = ($urandom_range(0, 63) == 0);
            step(s, c, sp);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
